scalar_wb_arbiter: RTL and testbench

SCALAR_WB_ARBITER -- requirements
Module: scalar_wb_arbiter

---
 rtl/scalar_wb_arbiter_if.sv | 32 +++
 rtl/scalar_wb_arbiter.sv | 103 ++++++++++
 tb/tb_scalar_wb_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/scalar_wb_arbiter_if.sv
// Result-source and writeback bundle between the functional units and the
// writeback arbiter.
interface scalar_wb_arbiter_if #(
    parameter int NSRC = 3,
    parameter int DW   = 32,
    parameter int RW   = 5
);
    // Handshake: a source result transfers on a rising edge where src_valid[i]
    // and src_ready[i] are both high; a source holds rd/data stable while it
    // waits. wb_* and fu_done are single-cycle strobes with no back-pressure.
    logic [NSRC-1:0]         src_valid;
    logic [NSRC-1:0]         src_ready;
    logic [NSRC-1:0][RW-1:0] src_rd;
    logic [NSRC-1:0][DW-1:0] src_data;
    logic                    flush;
    logic                    wb_valid;
    logic                    wb_en;
    logic [RW-1:0]           wb_reg;
    logic [DW-1:0]           wb_data;
    logic [1:0]              wb_src;
    logic [NSRC-1:0]         fu_done;

    modport master (
        output src_valid, src_rd, src_data, flush,
        input  src_ready, wb_valid, wb_en, wb_reg, wb_data, wb_src, fu_done
    );

    modport slave (
        input  src_valid, src_rd, src_data, flush,
        output src_ready, wb_valid, wb_en, wb_reg, wb_data, wb_src, fu_done
    );
endinterface

// File: rtl/scalar_wb_arbiter.sv
// Writeback arbiter: one holding buffer per result source, round-robin
// retirement of one result per cycle, with flush squash.
module scalar_wb_arbiter #(
    parameter int NSRC = 3,
    parameter int DW   = 32,
    parameter int RW   = 5,
    localparam int PW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    scalar_wb_arbiter_if.slave   bus,
    output logic [PW-1:0]        dbg_rr_ptr,
    output logic [NSRC-1:0]      dbg_buf_valid
);
    logic [NSRC-1:0]         buf_valid_q, buf_valid_d;
    logic [NSRC-1:0][RW-1:0] buf_rd_q, buf_rd_d;
    logic [NSRC-1:0][DW-1:0] buf_data_q, buf_data_d;
    logic [PW-1:0]           rr_ptr_q, rr_ptr_d;

    logic [NSRC-1:0] grant;
    logic [NSRC-1:0] capture;
    logic [NSRC-1:0] ready;
    logic            any_grant;
    logic [PW-1:0]   gidx;
    logic [PW:0]     scan;

    // Round-robin search starting at rr_ptr; flush and reset suppress any grant.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        gidx      = '0;
        scan      = '0;
        for (int k = 0; k < NSRC; k++) begin
            scan = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (scan >= (PW+1)'(NSRC)) scan = scan - (PW+1)'(NSRC);
            if (!any_grant && buf_valid_q[scan[PW-1:0]] && !bus.flush && !RST) begin
                any_grant               = 1'b1;
                gidx                    = scan[PW-1:0];
                grant[scan[PW-1:0]]     = 1'b1;
            end
        end
    end

    assign ready   = (~buf_valid_q | grant) & {NSRC{!bus.flush && !RST}};
    assign capture = bus.src_valid & ready;

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_rd_d    = buf_rd_q;
        buf_data_d  = buf_data_q;
        rr_ptr_d    = rr_ptr_q;
        for (int i = 0; i < NSRC; i++) begin
            // A capture on the grant edge reloads instead of clearing.
            if (capture[i]) begin
                buf_valid_d[i] = 1'b1;
                buf_rd_d[i]    = bus.src_rd[i];
                buf_data_d[i]  = bus.src_data[i];
            end else if (grant[i]) begin
                buf_valid_d[i] = 1'b0;
            end
        end
        if (bus.flush) buf_valid_d = '0;
        if (any_grant) begin
            rr_ptr_d = (gidx == PW'(NSRC-1)) ? '0 : gidx + PW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_valid_q <= '0;
            buf_rd_q    <= '0;
            buf_data_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_rd_q    <= buf_rd_d;
            buf_data_q  <= buf_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    always_comb begin
        bus.wb_reg  = '0;
        bus.wb_data = '0;
        bus.wb_src  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
                bus.wb_reg  = buf_rd_q[i];
                bus.wb_data = buf_data_q[i];
                bus.wb_src  = 2'(i);
            end
        end
    end

    // Register 0 retires normally but never writes the register file.
    assign bus.wb_valid  = any_grant;
    assign bus.wb_en     = any_grant && (bus.wb_reg != '0);
    assign bus.fu_done   = grant;
    assign bus.src_ready = ready;

    assign dbg_rr_ptr    = rr_ptr_q;
    assign dbg_buf_valid = buf_valid_q;
endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Directed bench for scalar_wb_arbiter: hand-computed retirement order is
// queued at issue time and checked by an independent writeback monitor.
module tb_scalar_wb_arbiter;
    localparam int NSRC = 3;
    localparam int DW   = 32;
    localparam int RW   = 5;
    localparam int EW   = 2 + RW + DW + 1;

    logic clk;
    logic rst;
    logic [1:0]      dbg_rr_ptr;
    logic [NSRC-1:0] dbg_buf_valid;

    int n_checks;
    int n_fail;
    logic [EW-1:0] exp_q[$];

    scalar_wb_arbiter_if #(.NSRC(NSRC), .DW(DW), .RW(RW)) bus ();

    scalar_wb_arbiter #(.NSRC(NSRC), .DW(DW), .RW(RW)) dut (
        .CLK           (clk),
        .RST           (rst),
        .bus           (bus),
        .dbg_rr_ptr    (dbg_rr_ptr),
        .dbg_buf_valid (dbg_buf_valid)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic cycle_start();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic offer(input int idx, input logic [RW-1:0] rd, input logic [DW-1:0] data);
        bus.src_valid[idx] = 1'b1;
        bus.src_rd[idx]    = rd;
        bus.src_data[idx]  = data;
    endtask

    task automatic push_exp(input logic [1:0] src, input logic [RW-1:0] rd, input logic [DW-1:0] data);
        exp_q.push_back({src, rd, data, (rd != '0)});
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [EW-1:0]   got;
        logic [EW-1:0]   e;
        logic [NSRC-1:0] fu_exp;
        if (bus.wb_valid === 1'b1) begin
            got = {bus.wb_src, bus.wb_reg, bus.wb_data, bus.wb_en};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_retire: got src=%0d reg=%0d data=0x%0h with nothing expected at %0t",
                         bus.wb_src, bus.wb_reg, bus.wb_data, $time);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL retire: got src=%0d reg=%0d data=0x%0h en=%0b expected src=%0d reg=%0d data=0x%0h en=%0b at %0t",
                             got[EW-1 -: 2], got[EW-3 -: RW], got[DW:1], got[0],
                             e[EW-1 -: 2], e[EW-3 -: RW], e[DW:1], e[0], $time);
                end
                fu_exp = NSRC'(1) << e[EW-1 -: 2];
                n_checks++;
                if (bus.fu_done !== fu_exp) begin
                    n_fail++;
                    $display("FAIL fu_done: got %b expected %b at %0t", bus.fu_done, fu_exp, $time);
                end
            end
        end
    end

    // Stimulus
    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.src_valid = '0;
        bus.src_rd    = '0;
        bus.src_data  = '0;
        bus.flush     = 1'b0;

        // Reset held: outputs forced low
        sample();
        check("rst_src_ready", 64'(bus.src_ready), 64'b000);
        check("rst_wb_valid",  64'(bus.wb_valid),  64'd0);
        cycle_start();
        rst = 1'b0;
        sample();
        check("post_rst_src_ready", 64'(bus.src_ready), 64'b111);
        check("post_rst_wb", 64'({bus.wb_valid, bus.wb_en, bus.wb_reg, bus.wb_data, bus.wb_src, bus.fu_done}), 64'd0);
        check("post_rst_rr_ptr", 64'(dbg_rr_ptr), 64'd0);

        // Single ALU result, retires next cycle
        cycle_start();
        offer(0, 5'd7, 32'hDEADBEEF);
        push_exp(2'd0, 5'd7, 32'hDEADBEEF);
        sample();
        check("single_ready", 64'(bus.src_ready), 64'b111);
        check("single_no_early_retire", 64'(bus.wb_valid), 64'd0);
        cycle_start();
        bus.src_valid = '0;
        sample();
        check("single_wb_en", 64'(bus.wb_en), 64'd1);
        check("single_fu_done", 64'(bus.fu_done), 64'b001);

        // LD/ST to r0: retires without a register write
        cycle_start();
        offer(1, 5'd0, 32'h12345678);
        push_exp(2'd1, 5'd0, 32'h12345678);
        cycle_start();
        bus.src_valid = '0;
        sample();
        check("r0_wb_valid", 64'(bus.wb_valid), 64'd1);
        check("r0_wb_en", 64'(bus.wb_en), 64'd0);
        check("r0_fu_done", 64'(bus.fu_done), 64'b010);

        // Branch-link result brings rr_ptr back to 0
        cycle_start();
        offer(2, 5'd31, 32'hCAFEF00D);
        push_exp(2'd2, 5'd31, 32'hCAFEF00D);
        cycle_start();
        bus.src_valid = '0;
        cycle_start();
        sample();
        check("rr_wrap", 64'(dbg_rr_ptr), 64'd0);

        // All three sources at once: drain 0,1,2
        cycle_start();
        offer(0, 5'd1, 32'h000000A1);
        offer(1, 5'd2, 32'h000000B2);
        offer(2, 5'd3, 32'h000000C3);
        push_exp(2'd0, 5'd1, 32'h000000A1);
        push_exp(2'd1, 5'd2, 32'h000000B2);
        push_exp(2'd2, 5'd3, 32'h000000C3);
        sample();
        check("all3_ready", 64'(bus.src_ready), 64'b111);
        cycle_start();
        bus.src_valid = '0;
        sample();
        check("all3_c1_ready", 64'(bus.src_ready), 64'b001);
        check("all3_c1_bufs", 64'(dbg_buf_valid), 64'b111);
        cycle_start();
        sample();
        check("all3_c2_ready", 64'(bus.src_ready), 64'b011);
        cycle_start();
        sample();
        check("all3_c3_ready", 64'(bus.src_ready), 64'b111);

        // Two buffered results squashed by flush
        cycle_start();
        offer(0, 5'd4, 32'h44444444);
        offer(1, 5'd5, 32'h55555555);
        cycle_start();
        bus.src_valid = '0;
        bus.flush     = 1'b1;
        sample();
        check("flush_wb_valid", 64'(bus.wb_valid), 64'd0);
        check("flush_fu_done", 64'(bus.fu_done), 64'd0);
        check("flush_ready", 64'(bus.src_ready), 64'b000);
        cycle_start();
        bus.flush = 1'b0;
        sample();
        check("flush_bufs_empty", 64'(dbg_buf_valid), 64'b000);
        check("flush_ready_after", 64'(bus.src_ready), 64'b111);
        check("flush_rr_hold", 64'(dbg_rr_ptr), 64'd0);
        repeat (3) cycle_start();

        // ALU streaming while LD/ST waits
        cycle_start();
        offer(0, 5'd8, 32'h00000100);
        offer(1, 5'd9, 32'h00000900);
        push_exp(2'd0, 5'd8, 32'h00000100);
        push_exp(2'd1, 5'd9, 32'h00000900);
        push_exp(2'd0, 5'd8, 32'h00000101);
        push_exp(2'd0, 5'd8, 32'h00000102);
        push_exp(2'd0, 5'd8, 32'h00000103);
        cycle_start();
        bus.src_valid[1] = 1'b0;
        offer(0, 5'd8, 32'h00000101);
        sample();
        check("stream_e1_ready", 64'(bus.src_ready), 64'b101);
        cycle_start();
        offer(0, 5'd8, 32'h00000102);
        sample();
        check("stream_e2_ready", 64'(bus.src_ready), 64'b110);
        check("stream_e2_ldst_grant", 64'(bus.fu_done), 64'b010);
        cycle_start();
        sample();
        check("stream_e3_ready", 64'(bus.src_ready), 64'b111);
        cycle_start();
        offer(0, 5'd8, 32'h00000103);
        sample();
        check("stream_e4_ready", 64'(bus.src_ready), 64'b111);
        cycle_start();
        bus.src_valid = '0;
        sample();
        check("stream_rr_ptr", 64'(dbg_rr_ptr), 64'd1);
        cycle_start();

        // Reset with all buffers full discards them
        cycle_start();
        offer(0, 5'd10, 32'hA0A0A0A0);
        offer(1, 5'd11, 32'hB0B0B0B0);
        offer(2, 5'd12, 32'hC0C0C0C0);
        cycle_start();
        bus.src_valid = '0;
        rst           = 1'b1;
        sample();
        check("midrst_ready", 64'(bus.src_ready), 64'b000);
        check("midrst_wb_valid", 64'(bus.wb_valid), 64'd0);
        cycle_start();
        rst = 1'b0;
        sample();
        check("after_rst_wb", 64'({bus.wb_valid, bus.wb_en, bus.wb_reg, bus.wb_data, bus.wb_src, bus.fu_done}), 64'd0);
        check("after_rst_ready", 64'(bus.src_ready), 64'b111);
        check("after_rst_rr_ptr", 64'(dbg_rr_ptr), 64'd0);
        check("after_rst_bufs", 64'(dbg_buf_valid), 64'b000);
        repeat (3) cycle_start();

        // Bounded drain of the expected queue
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle_start();
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
